// File: rtl/inv_table_lookup_pkg.sv
// Shared definitions for the AES inverse T-table lookup block: FSM encoding,
// GF(2^8) coefficients and the arithmetic helpers used by the datapath.
package inv_table_lookup_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] COEF_E   = 8'h0e;
  localparam logic [7:0] COEF_9   = 8'h09;
  localparam logic [7:0] COEF_D   = 8'h0d;
  localparam logic [7:0] COEF_B   = 8'h0b;
  localparam logic [7:0] RED_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [31:0] td0_word(input logic [7:0] s);
    return {gf_mul(COEF_E, s), gf_mul(COEF_9, s), gf_mul(COEF_D, s), gf_mul(COEF_B, s)};
  endfunction

endpackage

// File: rtl/inv_table_lookup_inv_s.sv
// Registered AES inverse S-box: inverse affine transform then GF(2^8) inversion,
// result available one clock after the byte is presented.
module inv_s
  import inv_table_lookup_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in,
  output logic [7:0] out
);

  logic [7:0] affine_d;
  logic [7:0] out_q;

  assign affine_d = {in[6:0], in[7]} ^ {in[4:0], in[7:5]} ^ {in[1:0], in[7:2]} ^ 8'h05;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 8'h00;
    else        out_q <= gf_inv(affine_d);
  end

  assign out = out_q;

endmodule

// File: rtl/inv_table_lookup.sv
// Computes Td0..Td3 decryption T-table words for one 32-bit column, feeding one
// byte per cycle through a shared registered inverse S-box.
module inv_table_lookup
  import inv_table_lookup_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] state,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p0,
  output logic [31:0] p1,
  output logic [31:0] p2,
  output logic [31:0] p3
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] td0_q [4];
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic [1:0]  wr_idx;
  logic        accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == 3'd4) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    sbox_in = word_q[31:24];
      2'd1:    sbox_in = word_q[23:16];
      2'd2:    sbox_in = word_q[15:8];
      default: sbox_in = word_q[7:0];
    endcase
  end

  inv_s u_inv_s (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (sbox_in),
    .out   (sbox_out)
  );

  // The S-box result lags its byte by one cycle, so slot k is written when the counter reads k+1.
  assign wr_idx = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 3'd0;
      word_q <= 32'h0;
      for (int i = 0; i < 4; i++) td0_q[i] <= 32'h0;
    end else if (accept) begin
      cnt_q  <= 3'd0;
      word_q <= state;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q != 3'd0) td0_q[wr_idx] <= td0_word(sbox_out);
    end
  end

  assign p0 = td0_q[0];
  assign p1 = {td0_q[1][7:0],  td0_q[1][31:8]};
  assign p2 = {td0_q[2][15:0], td0_q[2][31:16]};
  assign p3 = {td0_q[3][23:0], td0_q[3][31:24]};

endmodule

// File: tb/tb_inv_table_lookup.sv
// Self-checking bench for inv_table_lookup: a table-driven AES reference model
// checks every valid output cycle, alongside directed literal vectors.
module tb_inv_table_lookup;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        outReady;
  logic [31:0] stateIn;
  logic        inReady;
  logic        outValid;
  logic [31:0] p0, p1, p2, p3;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  invTable [256];
  logic [31:0] expWord = 32'h0;
  bit          b2bMode = 1'b0;
  int          cycle = 0;
  int          lastAcc = -1;
  int          accCount = 0;

  inv_table_lookup dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .state     (stateIn),
    .in_ready  (inReady),
    .out_valid (outValid),
    .out_ready (outReady),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: polynomial product reduced by the full modulus 0x11b.
  function automatic logic [7:0] mMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int bitPos = 14; bitPos >= 8; bitPos--)
      if (prod[bitPos]) prod = prod ^ (16'h011b << (bitPos - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Forward S-box by brute-force inverse search; the inverse table is built by inverting it.
  function automatic logic [7:0] fwdSbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++) if (mMul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] modelTd0(input logic [7:0] b);
    logic [7:0] s;
    s = invTable[b];
    return {mMul(8'h0e, s), mMul(8'h09, s), mMul(8'h0d, s), mMul(8'h0b, s)};
  endfunction

  function automatic logic [31:0] modelP(input logic [31:0] w, input int k);
    logic [31:0] t;
    logic [63:0] tt;
    t  = modelTd0(w[31 - 8 * k -: 8]);
    tt = {t, t} >> (8 * k);
    return tt[31:0];
  endfunction

  // Track the accepted word and, in back-to-back mode, the spacing between accepts.
  always @(posedge clk) begin
    cycle++;
    if (rstN === 1'b1 && inValid && inReady) begin
      expWord <= stateIn;
      if (b2bMode) begin
        if (lastAcc >= 0) checkOutput("b2b_spacing", cycle - lastAcc, 32'd7);
        lastAcc = cycle;
        accCount++;
      end
    end
  end

  always @(negedge clk) begin
    if (rstN === 1'b1 && outValid === 1'b1) begin
      checkOutput("p0", p0, modelP(expWord, 0));
      checkOutput("p1", p1, modelP(expWord, 1));
      checkOutput("p2", p2, modelP(expWord, 2));
      checkOutput("p3", p3, modelP(expWord, 3));
    end
  end

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic applyStimulus(input logic [31:0] w, input int hold);
    int n;
    outReady = (hold == 0);
    inValid  = 1'b1;
    stateIn  = w;
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    stateIn = $urandom;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!outValid && n < 8);
    checkOutput("latency", n, 32'd5);
    for (int i = 0; i < hold; i++) begin
      inValid = 1'b1;
      stateIn = $urandom;
      @(negedge clk);
      checkOutput("hold_in_ready", 32'(inReady), 32'd0);
      checkOutput("hold_out_valid", 32'(outValid), 32'd1);
      @(posedge clk);
      #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_hs_out_valid", 32'(outValid), 32'd0);
    checkOutput("post_hs_in_ready", 32'(inReady), 32'd1);
    checkOutput("retain_p0", p0, modelP(w, 0));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seenValid;
    logic [7:0] bj;
    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    stateIn  = 32'h0;

    for (int x = 0; x < 256; x++) invTable[fwdSbox(8'(x))] = 8'(x);

    checkOutput("pin_invsbox_00", 32'(invTable[8'h00]), 32'h52);
    checkOutput("pin_td0_00", modelTd0(8'h00), 32'h51f4a750);
    checkOutput("pin_td0_7c", modelTd0(8'h7c), 32'h0e090d0b);
    checkOutput("pin_td0_63", modelTd0(8'h63), 32'h00000000);
    checkOutput("pin_p3_00", modelP(32'h0, 3), 32'hf4a75051);

    #12;
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_p0", p0, 32'h0);
    checkOutput("rst_p1", p1, 32'h0);
    checkOutput("rst_p2", p2, 32'h0);
    checkOutput("rst_p3", p3, 32'h0);

    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(32'h00000000, 0);
    checkOutput("zero_p0", p0, 32'h51f4a750);
    checkOutput("zero_p1", p1, 32'h5051f4a7);
    checkOutput("zero_p2", p2, 32'ha75051f4);
    checkOutput("zero_p3", p3, 32'hf4a75051);

    applyStimulus(32'h7c7c7c7c, 0);
    checkOutput("7c_p0", p0, 32'h0e090d0b);
    checkOutput("7c_p1", p1, 32'h0b0e090d);
    checkOutput("7c_p2", p2, 32'h0d0b0e09);
    checkOutput("7c_p3", p3, 32'h090d0b0e);

    applyStimulus(32'h63636363, 0);
    checkOutput("63_p0", p0, 32'h0);
    checkOutput("63_p1", p1, 32'h0);
    checkOutput("63_p2", p2, 32'h0);
    checkOutput("63_p3", p3, 32'h0);

    applyStimulus(32'hdeadbeef, 10);

    // Abort a run after two bytes have been presented.
    inValid = 1'b1;
    stateIn = 32'h01234567;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midrst_p0", p0, 32'h0);
    checkOutput("midrst_p1", p1, 32'h0);
    checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    seenValid = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (outValid) seenValid++;
    end
    checkOutput("midrst_no_valid", seenValid, 32'd0);
    @(negedge clk);
    applyStimulus(32'h7c7c7c7c, 0);
    checkOutput("after_rst_p1", p1, 32'h0b0e090d);

    for (int j = 0; j < 256; j++) begin
      bj = 8'(j);
      applyStimulus({bj, bj + 8'd64, bj + 8'd128, bj + 8'd192}, 0);
    end

    // Spacing of 7 edges: 5 to DONE, 1 for the handshake, 1 back in IDLE.
    b2bMode  = 1'b1;
    outReady = 1'b1;
    inValid  = 1'b1;
    stateIn  = $urandom;
    repeat (45) begin
      @(posedge clk);
      #1;
      stateIn = $urandom;
    end
    inValid = 1'b0;
    b2bMode = 1'b0;
    repeat (12) @(posedge clk);
    checkOutput("b2b_count", accCount, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
